// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions: load/store kind encodings and memory-stage FSM states.
package memory_stage_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } load_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_e;

    // A store wins over a simultaneous load; unused load codes decode to none.
    function automatic load_e decode_load(input logic [2:0] ld_raw, input logic [1:0] st_raw);
        load_e ld;
        ld = LD_NONE;
        if (st_raw == 2'd0) begin
            case (ld_raw)
                3'd1, 3'd2, 3'd3, 3'd4, 3'd5: ld = load_e'(ld_raw);
                default:                      ld = LD_NONE;
            endcase
        end
        return ld;
    endfunction

endpackage

// File: rtl/memory_stage_load_formatter.sv
// Combinational load data formatter: lane select plus sign/zero extension of the read word.
module load_formatter
    import memory_stage_pkg::*;
(
    input  load_e       info_load,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = '0;
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        case (info_load)
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'd0, byte_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'd0, half_sel};
            LD_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues one data-memory request at a time and formats the writeback.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2E,
    input  logic        write_regE,
    input  logic [2:0]  info_loadE,
    input  logic [1:0]  info_storeE,
    input  logic [4:0]  dstreg_addrE,
    output logic        busy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        valid_out,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        misalign_err
);

    state_e      state_q;
    logic        dmem_req_q, dmem_we_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_be_q;
    logic        valid_out_q, wb_we_q, misalign_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    load_e       ld_q;
    logic [1:0]  off_q;
    logic        load_wr_q;

    store_e      st_d;
    load_e       ld_d;
    logic        half_d, word_d, misalign_d, is_mem_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] fmt_data;

    always_comb begin
        st_d       = store_e'(info_storeE);
        ld_d       = decode_load(info_loadE, info_storeE);
        half_d     = (st_d == ST_SH) || (ld_d == LD_LH) || (ld_d == LD_LHU);
        word_d     = (st_d == ST_SW) || (ld_d == LD_LW);
        misalign_d = (half_d && alu_result[0]) || (word_d && (alu_result[1:0] != 2'b00));
        is_mem_d   = (st_d != ST_NONE) || (ld_d != LD_NONE);
        be_d       = '0;
        wdata_d    = '0;
        case (st_d)
            ST_SB: begin
                be_d    = 4'b0001 << alu_result[1:0];
                wdata_d = {4{rs2E[7:0]}};
            end
            ST_SH: begin
                be_d    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{rs2E[15:0]}};
            end
            ST_SW: begin
                be_d    = 4'b1111;
                wdata_d = rs2E;
            end
            default: begin
                be_d    = '0;
                wdata_d = '0;
            end
        endcase
    end

    load_formatter u_load_formatter (
        .info_load (ld_q),
        .addr_lo   (off_q),
        .rdata     (dmem_rdata),
        .data      (fmt_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            valid_out_q  <= 1'b0;
            wb_we_q      <= 1'b0;
            misalign_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            ld_q         <= LD_NONE;
            off_q        <= '0;
            load_wr_q    <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            wb_we_q     <= 1'b0;
            misalign_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        wb_addr_q <= dstreg_addrE;
                        if (is_mem_d && !misalign_d) begin
                            state_q      <= S_WAIT_ACK;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= (st_d != ST_NONE);
                            dmem_addr_q  <= {alu_result[31:2], 2'b00};
                            dmem_wdata_q <= wdata_d;
                            dmem_be_q    <= be_d;
                            ld_q         <= ld_d;
                            off_q        <= alu_result[1:0];
                            load_wr_q    <= write_regE && (ld_d != LD_NONE);
                        end else begin
                            // Misaligned memory ops retire like ALU ops but never write.
                            valid_out_q <= 1'b1;
                            wb_we_q     <= write_regE && !misalign_d;
                            wb_data_q   <= alu_result;
                            misalign_q  <= misalign_d;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (dmem_ack) begin
                        state_q     <= S_IDLE;
                        dmem_req_q  <= 1'b0;
                        dmem_we_q   <= 1'b0;
                        valid_out_q <= 1'b1;
                        wb_we_q     <= load_wr_q;
                        wb_data_q   <= fmt_data;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state_q == S_WAIT_ACK);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign dmem_be      = dmem_be_q;
    assign valid_out    = valid_out_q;
    assign wb_we        = wb_we_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: driver queues expectations, a memory responder and a writeback monitor check them.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2E = '0;
    logic        write_regE = 1'b0;
    logic [2:0]  info_loadE = '0;
    logic [1:0]  info_storeE = '0;
    logic [4:0]  dstreg_addrE = '0;
    logic        busy, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        valid_out, wb_we, misalign_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        int unsigned cyc;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        chk_wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int unsigned d;
    } mem_t;

    wb_t  wbq[$];
    mem_t mq[$];

    memory_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .alu_result   (alu_result),
        .rs2E         (rs2E),
        .write_regE   (write_regE),
        .info_loadE   (info_loadE),
        .info_storeE  (info_storeE),
        .dstreg_addrE (dstreg_addrE),
        .busy         (busy),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .valid_out    (valid_out),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mem_t mreq(input logic [31:0] addr, input logic we, input logic chk_wr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input logic [31:0] rdata, input int unsigned d);
        mem_t m;
        m = '{addr, we, chk_wr, wdata, be, rdata, d};
        return m;
    endfunction

    function automatic wb_t wbx(input logic we, input logic [4:0] addr, input logic [31:0] data,
                                input logic chk_data, input logic mis);
        wb_t w;
        w = '{we, addr, data, chk_data, mis, 0};
        return w;
    endfunction

    // Presents an op (valid_in left high), waits for acceptance, queues expectations.
    task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic wr,
                         input logic [2:0] ld, input logic [1:0] st, input logic [4:0] dst,
                         input logic is_mem, input mem_t m, input wb_t w, input logic push_wb);
        int unsigned n;
        alu_result   = alu;
        rs2E         = rs2;
        write_regE   = wr;
        info_loadE   = ld;
        info_storeE  = st;
        dstreg_addrE = dst;
        valid_in     = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, busy}, 32'd0);
        w.cyc = cyc + 1 + (is_mem ? m.d : 0);
        if (is_mem) mq.push_back(m);
        if (push_wb) wbq.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},       {31'd0, busy},         32'd0);
        chk({tag, "_dmem_req"},   {31'd0, dmem_req},     32'd0);
        chk({tag, "_dmem_we"},    {31'd0, dmem_we},      32'd0);
        chk({tag, "_valid_out"},  {31'd0, valid_out},    32'd0);
        chk({tag, "_wb_we"},      {31'd0, wb_we},        32'd0);
        chk({tag, "_misalign"},   {31'd0, misalign_err}, 32'd0);
        chk({tag, "_dmem_addr"},  dmem_addr,             32'd0);
        chk({tag, "_dmem_wdata"}, dmem_wdata,            32'd0);
        chk({tag, "_dmem_be"},    {28'd0, dmem_be},      32'd0);
        chk({tag, "_wb_addr"},    {27'd0, wb_addr},      32'd0);
        chk({tag, "_wb_data"},    wb_data,               32'd0);
    endtask

    // Writeback monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_out === 1'b1) begin
                if (wbq.size() == 0) begin
                    chk("unexpected_valid_out", {31'd0, valid_out}, 32'd0);
                end else begin
                    wb_t e;
                    e = wbq.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                    chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                    chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end else begin
                chk("idle_wb_we", {31'd0, wb_we}, 32'd0);
                chk("idle_misalign", {31'd0, misalign_err}, 32'd0);
            end
        end
    end

    // Memory responder
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && dmem_req === 1'b1) begin
                if (mq.size() == 0) begin
                    chk("unexpected_dmem_req", {31'd0, dmem_req}, 32'd0);
                    for (int k = 0; k < 50 && dmem_req; k++) @(negedge clk);
                end else begin
                    mem_t m;
                    logic [31:0] a0, w0;
                    logic [3:0]  b0;
                    logic        we0;
                    m = mq.pop_front();
                    chk("dmem_addr", dmem_addr, m.addr);
                    chk("dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
                    if (m.chk_wr) begin
                        chk("dmem_wdata", dmem_wdata, m.wdata);
                        chk("dmem_be", {28'd0, dmem_be}, {28'd0, m.be});
                    end
                    a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be; we0 = dmem_we;
                    if (m.d == 0) begin
                        for (int k = 0; k < 50 && dmem_req; k++) @(negedge clk);
                    end else begin
                        for (int k = 1; k < m.d; k++) begin
                            @(negedge clk);
                            chk("hold_req", {31'd0, dmem_req}, 32'd1);
                            chk("hold_busy", {31'd0, busy}, 32'd1);
                            chk("hold_addr", dmem_addr, a0);
                            chk("hold_wdata", dmem_wdata, w0);
                            chk("hold_be_we", {27'd0, dmem_be, dmem_we}, {27'd0, b0, we0});
                        end
                        dmem_rdata = m.rdata;
                        dmem_ack   = 1'b1;
                        @(posedge clk);
                        #1;
                        dmem_ack   = 1'b0;
                        dmem_rdata = '0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    mem_t nom;

    initial begin
        nom = mreq('0, 1'b0, 1'b0, '0, '0, '0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU op
        issue(32'h0000_1234, 32'h0, 1'b1, 3'd0, 2'd0, 5'd5, 1'b0, nom,
              wbx(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0), 1'b1);
        idle(2);
        // SB, ack on third wait cycle
        issue(32'h0000_0103, 32'h0000_00AB, 1'b1, 3'd0, 2'd1, 5'd7, 1'b1,
              mreq(32'h100, 1'b1, 1'b1, 32'hABAB_ABAB, 4'b1000, 32'h0, 3),
              wbx(1'b0, 5'd7, 32'h0, 1'b0, 1'b0), 1'b1);
        idle(5);
        // LB / LBU
        issue(32'h0000_0102, 32'h0, 1'b1, 3'd1, 2'd0, 5'd3, 1'b1,
              mreq(32'h100, 1'b0, 1'b0, '0, '0, 32'h0080_0000, 1),
              wbx(1'b1, 5'd3, 32'hFFFF_FF80, 1'b1, 1'b0), 1'b1);
        idle(3);
        issue(32'h0000_0102, 32'h0, 1'b1, 3'd4, 2'd0, 5'd4, 1'b1,
              mreq(32'h100, 1'b0, 1'b0, '0, '0, 32'h0080_0000, 1),
              wbx(1'b1, 5'd4, 32'h0000_0080, 1'b1, 1'b0), 1'b1);
        idle(3);
        // Misaligned LW
        issue(32'h0000_0102, 32'h0, 1'b1, 3'd3, 2'd0, 5'd6, 1'b0, nom,
              wbx(1'b0, 5'd6, 32'h0000_0102, 1'b1, 1'b1), 1'b1);
        idle(2);
        // LH, LHU, LW
        issue(32'h0000_0102, 32'h0, 1'b1, 3'd2, 2'd0, 5'd8, 1'b1,
              mreq(32'h100, 1'b0, 1'b0, '0, '0, 32'h8001_0000, 2),
              wbx(1'b1, 5'd8, 32'hFFFF_8001, 1'b1, 1'b0), 1'b1);
        idle(4);
        issue(32'h0000_0106, 32'h0, 1'b1, 3'd5, 2'd0, 5'd10, 1'b1,
              mreq(32'h104, 1'b0, 1'b0, '0, '0, 32'h9ABC_1234, 1),
              wbx(1'b1, 5'd10, 32'h0000_9ABC, 1'b1, 1'b0), 1'b1);
        idle(3);
        issue(32'h0000_0104, 32'h0, 1'b1, 3'd3, 2'd0, 5'd11, 1'b1,
              mreq(32'h104, 1'b0, 1'b0, '0, '0, 32'hDEAD_BEEF, 2),
              wbx(1'b1, 5'd11, 32'hDEAD_BEEF, 1'b1, 1'b0), 1'b1);
        idle(4);
        // SH, SW
        issue(32'h0000_0106, 32'h1234_5678, 1'b1, 3'd0, 2'd2, 5'd12, 1'b1,
              mreq(32'h104, 1'b1, 1'b1, 32'h5678_5678, 4'b1100, 32'h0, 1),
              wbx(1'b0, 5'd12, 32'h0, 1'b0, 1'b0), 1'b1);
        idle(3);
        issue(32'h0000_0108, 32'hCAFE_F00D, 1'b0, 3'd0, 2'd3, 5'd13, 1'b1,
              mreq(32'h108, 1'b1, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0, 2),
              wbx(1'b0, 5'd13, 32'h0, 1'b0, 1'b0), 1'b1);
        idle(4);
        // Store and load together: store executes
        issue(32'h0000_0101, 32'h0000_0055, 1'b1, 3'd3, 2'd1, 5'd14, 1'b1,
              mreq(32'h100, 1'b1, 1'b1, 32'h5555_5555, 4'b0010, 32'hFFFF_FFFF, 1),
              wbx(1'b0, 5'd14, 32'h0, 1'b0, 1'b0), 1'b1);
        idle(3);
        // Load code 6 behaves as no load
        issue(32'h0000_55AA, 32'h0, 1'b1, 3'd6, 2'd0, 5'd9, 1'b0, nom,
              wbx(1'b1, 5'd9, 32'h0000_55AA, 1'b1, 1'b0), 1'b1);
        idle(2);
        // Misaligned SH and LH
        issue(32'h0000_0101, 32'h0000_BEEF, 1'b1, 3'd0, 2'd2, 5'd15, 1'b0, nom,
              wbx(1'b0, 5'd15, 32'h0000_0101, 1'b1, 1'b1), 1'b1);
        idle(2);
        issue(32'h0000_0103, 32'h0, 1'b1, 3'd2, 2'd0, 5'd16, 1'b0, nom,
              wbx(1'b0, 5'd16, 32'h0000_0103, 1'b1, 1'b1), 1'b1);
        idle(2);
        // Back-to-back loads, valid_in held high between them
        issue(32'h0000_0200, 32'h0, 1'b1, 3'd3, 2'd0, 5'd17, 1'b1,
              mreq(32'h200, 1'b0, 1'b0, '0, '0, 32'h1111_1111, 2),
              wbx(1'b1, 5'd17, 32'h1111_1111, 1'b1, 1'b0), 1'b1);
        issue(32'h0000_0204, 32'h0, 1'b1, 3'd3, 2'd0, 5'd18, 1'b1,
              mreq(32'h204, 1'b0, 1'b0, '0, '0, 32'h2222_2222, 1),
              wbx(1'b1, 5'd18, 32'h2222_2222, 1'b1, 1'b0), 1'b1);
        idle(4);
        chk("b2b_wb_drained", wbq.size(), 32'd0);
        chk("b2b_req_drained", mq.size(), 32'd0);

        // Reset while waiting for ack, then a stray ack
        issue(32'h0000_0300, 32'h0, 1'b1, 3'd3, 2'd0, 5'd19, 1'b1,
              mreq(32'h300, 1'b0, 1'b0, '0, '0, 32'h0, 0),
              wbx(1'b1, 5'd19, 32'h0, 1'b0, 1'b0), 1'b0);
        valid_in = 1'b0;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rdata = 32'h7777_7777;
        dmem_ack   = 1'b1;
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        chk("stray_ack_valid_out", {31'd0, valid_out}, 32'd0);
        chk("stray_ack_busy", {31'd0, busy}, 32'd0);
        chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
        idle(3);
        chk("final_wb_queue", wbq.size(), 32'd0);
        chk("final_req_queue", mq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
